ahb_sram_slave: RTL and testbench

AHB-Lite responder that pairs with `ahb_master` in the `top` bench. It decodes address and control phases, inserts a configurable number of wait states, and stores and returns data in a small byte-writable word memory. Transfers that are out of range, oversized or misaligned get the two-cycle ERROR response. It is the single slave on the bus, so its own `HREADY` output is the bus-ready that the master samples.

---
 rtl/ahb_pkg.sv | 50 +++++
 rtl/ahb_sram_mem.sv | 33 +++
 rtl/ahb_sram_slave.sv | 131 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and slave FSM state shared by master and slave
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } HTRANS_e;

    typedef enum logic [3:0] {
        BITS8  = 4'd0,
        BITS16 = 4'd1,
        BITS32 = 4'd2
    } HSIZE_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } HBURST_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } slave_state_e;

    // Little-endian byte-lane enables for a legal (size <= 2) transfer.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << lane;
            2'd1:    m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// rtl/ahb_sram_mem.sv - word memory with byte-enable write, combinational read, async clear
module ahb_sram_mem #(
    parameter int MEM_WORDS = 16,
    parameter int AW        = 4
) (
    input  logic          HCLK,
    input  logic          HREASETn,
    input  logic          wr_en,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge HCLK or negedge HREASETn) begin
        if (!HREASETn) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem[idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM responder with wait states and ERROR response
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HREASETn,
    input  logic        HSELx,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);
    localparam bit          HAS_WAIT  = (WAIT_STATES > 0);

    slave_state_e  state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          hready_q;
    logic          hresp_q;

    logic [32:0]   diff;
    logic          accept;
    logic          in_range;
    logic          oversize;
    logic          misalign;
    logic          addr_err;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic          unused_ok;

    // 33-bit difference: bit 32 set means the address lies below BASE_ADDR.
    assign diff     = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign in_range = !diff[32] && ({1'b0, diff[31:0]} < MEM_BYTES);
    assign oversize = HSIZE > 4'd2;
    assign misalign = (HSIZE == 4'd1 && HADDR[0]) || (HSIZE == 4'd2 && HADDR[1:0] != 2'b00);
    assign addr_err = !in_range || oversize || misalign;
    assign accept   = HSELx && HTRANS[1] && hready_q;
    assign unused_ok = ^{HBURST, HTRANS[0]};

    always_ff @(posedge HCLK or negedge HREASETn) begin
        if (!HREASETn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else if (accept) begin
            idx_q   <= diff[AW+1:2];
            lane_q  <= HADDR[1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE;
            if (addr_err) begin
                state    <= S_ERR1;
                hready_q <= 1'b0;
                hresp_q  <= HRESP_ERROR;
            end else if (HAS_WAIT) begin
                state    <= S_WAIT;
                wait_cnt <= WS;
                hready_q <= 1'b0;
                hresp_q  <= HRESP_OKAY;
            end else begin
                state    <= S_DATA;
                hready_q <= 1'b1;
                hresp_q  <= HRESP_OKAY;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state    <= S_DATA;
                        hready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state    <= S_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    state    <= S_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // The write lands on the DATA-ending edge, the same edge a following read is accepted.
    assign mem_we = (state == S_DATA) && write_q;
    assign mem_be = lane_mask(lane_q, size_q);

    ahb_sram_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .HCLK     (HCLK),
        .HREASETn (HREASETn),
        .wr_en    (mem_we),
        .wr_be    (mem_be),
        .idx      (idx_q),
        .wr_data  (HWDATA),
        .rd_data  (mem_rdata)
    );

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
    assign HRDATA = (state == S_DATA && !write_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized and directed bench for ahb_sram_slave with a transfer-level model
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;

    logic        HCLK = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  hsel;
    logic [1:0]  hwrite;
    logic [1:0]  hready;
    logic [1:0]  hresp;
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hburst [2];
    logic [3:0]  hsize  [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];

    int          vectors     = 0;
    int          miscompares = 0;
    int          ws [2];
    exp_t        exp_q [2][$];
    logic [31:0] mmem  [2][16];
    logic [31:0] cur_wd [2];
    exp_t        cmp_e;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HREASETn(rst_n[0]), .HSELx(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HBURST(hburst[0]), .HSIZE(hsize[0]), .HWRITE(hwrite[0]),
        .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_sram_slave #(.WAIT_STATES(3)) dut1 (
        .HCLK(HCLK), .HREASETn(rst_n[1]), .HSELx(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HBURST(hburst[1]), .HSIZE(hsize[1]), .HWRITE(hwrite[1]),
        .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    function automatic exp_t mk(input logic r, input logic e, input logic [31:0] d);
        exp_t x;
        x.rdy   = r;
        x.resp  = e;
        x.rdata = d;
        return x;
    endfunction

    // Every cycle, each bus must show the model's next expected beat (idle when nothing is owed).
    always @(negedge HCLK) begin
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() != 0) cmp_e = exp_q[d].pop_front();
            else                      cmp_e = mk(1'b1, 1'b0, 32'h0);
            vectors++;
            if ({hready[d], hresp[d], hrdata[d]} !== cmp_e) begin
                miscompares++;
                $display("FAIL cycle dut%0d t=%0t: ready/resp/rdata got %b/%b/%h want %b/%b/%h",
                         d, $time, hready[d], hresp[d], hrdata[d], cmp_e.rdy, cmp_e.resp, cmp_e.rdata);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_ready(input int d);
        int guard = 0;
        @(negedge HCLK); #1;
        while (exp_q[d].size() != 0) begin
            if (guard == 40) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_ready dut%0d: still busy after %0d cycles, want ready", d, guard);
                exp_q[d].delete();
                break;
            end
            guard++;
            @(negedge HCLK); #1;
        end
    endtask

    // Present one address phase and record what the bus owes for it.
    task automatic drive(input int d, input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic [3:0] sz, input logic w, input logic [31:0] wd);
        logic err;
        int   idx;
        hwdata[d] = cur_wd[d];
        hsel[d]   = sel;
        htrans[d] = tr;
        haddr[d]  = a;
        hsize[d]  = sz;
        hwrite[d] = w;
        hburst[d] = 3'($urandom_range(0, 7));
        if (sel && tr[1]) begin
            err = (a >= 32'd64) || (sz > 4'd2) || (sz == 4'd1 && a % 2 != 0) || (sz == 4'd2 && a % 4 != 0);
            if (err) begin
                exp_q[d].push_back(mk(1'b0, 1'b1, 32'h0));
                exp_q[d].push_back(mk(1'b1, 1'b1, 32'h0));
            end else begin
                idx = int'(a / 4);
                for (int i = 0; i < ws[d]; i++) exp_q[d].push_back(mk(1'b0, 1'b0, 32'h0));
                exp_q[d].push_back(mk(1'b1, 1'b0, w ? 32'h0 : mmem[d][idx]));
                if (w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (sz == 4'd2 || (sz == 4'd1 && k / 2 == (a % 4) / 2) || (sz == 4'd0 && k == a % 4))
                            mmem[d][idx][8*k +: 8] = wd[8*k +: 8];
                    end
                end
            end
            cur_wd[d] = wd;
        end
    endtask

    task automatic issue(input int d, input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic [3:0] sz, input logic w, input logic [31:0] wd);
        wait_ready(d);
        drive(d, sel, tr, a, sz, w, wd);
    endtask

    task automatic idle(input int d);
        issue(d, 1'b0, IDLE, 32'h0, 4'd0, 1'b0, 32'h0);
    endtask

    task automatic check_rd(input int d, input string name, input logic [31:0] want);
        wait_ready(d);
        check_lit(name, hrdata[d], want);
        drive(d, 1'b0, IDLE, 32'h0, 4'd0, 1'b0, 32'h0);
    endtask

    task automatic err_case(input int d, input logic [31:0] a, input logic [3:0] sz, input string name);
        issue(d, 1'b1, NONSEQ, a, sz, 1'b1, 32'hFFFF_FFFF);
        @(negedge HCLK); #1;
        check_lit({name, " ERR1 ready/resp"}, {30'h0, hready[d], hresp[d]}, 32'h1);
        @(negedge HCLK); #1;
        check_lit({name, " ERR2 ready/resp"}, {30'h0, hready[d], hresp[d]}, 32'h3);
        drive(d, 1'b0, IDLE, 32'h0, 4'd0, 1'b0, 32'h0);
    endtask

    task automatic random_run(input int d, input int n);
        int          word;
        int          lane;
        logic [3:0]  sz;
        logic [1:0]  tr;
        logic [31:0] a;
        int          t;
        for (int i = 0; i < n; i++) begin
            t    = $urandom_range(0, 9);
            tr   = (t == 0) ? IDLE : (t == 1) ? BUSY : (t < 6) ? NONSEQ : SEQ;
            sz   = ($urandom_range(0, 9) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
            word = $urandom_range(0, 19);
            if ($urandom_range(0, 7) == 0) lane = $urandom_range(0, 3);
            else if (sz == 4'd0)           lane = $urandom_range(0, 3);
            else if (sz == 4'd1)           lane = 2 * $urandom_range(0, 1);
            else                           lane = 0;
            a = (word == 19) ? 32'($urandom) : 32'(word * 4 + lane);
            issue(d, $urandom_range(0, 11) != 0, tr, a, sz, 1'($urandom_range(0, 1)), 32'($urandom));
        end
        for (int k = 0; k < 16; k++) issue(d, 1'b1, NONSEQ, 32'(4 * k), 4'd2, 1'b0, 32'h0);
        idle(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run time %0t exceeded limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int n;
        ws[0] = 0;
        ws[1] = 3;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) mmem[d][k] = 32'h0;
            cur_wd[d] = 32'h0;
            rst_n[d]  = 1'b0;
            drive(d, 1'b0, IDLE, 32'h0, 4'd0, 1'b0, 32'h0);
        end
        @(negedge HCLK); @(negedge HCLK); #1;
        for (int d = 0; d < 2; d++) begin
            check_lit("reset hready", {31'h0, hready[d]}, 32'h1);
            check_lit("reset hresp", {31'h0, hresp[d]}, 32'h0);
            check_lit("reset hrdata", hrdata[d], 32'h0);
        end
        #2 rst_n = 2'b11;

        // single word write / read
        issue(0, 1'b1, NONSEQ, 32'h38, 4'd2, 1'b1, 32'h0000_0138);
        wait_ready(0);
        check_lit("write okay ready/resp", {30'h0, hready[0], hresp[0]}, 32'h2);
        drive(0, 1'b1, NONSEQ, 32'h38, 4'd2, 1'b0, 32'h0);
        check_rd(0, "word readback", 32'h0000_0138);

        // byte and halfword lanes
        issue(0, 1'b1, NONSEQ, 32'h10, 4'd2, 1'b1, 32'h1122_3344);
        issue(0, 1'b1, NONSEQ, 32'h11, 4'd0, 1'b1, 32'h0000_AA00);
        issue(0, 1'b1, NONSEQ, 32'h12, 4'd1, 1'b1, 32'hBBCC_0000);
        issue(0, 1'b1, NONSEQ, 32'h10, 4'd2, 1'b0, 32'h0);
        check_rd(0, "byte/half lanes", 32'hBBCC_AA44);

        // errors leave memory untouched
        err_case(0, 32'h40, 4'd2, "out of range");
        err_case(0, 32'h38, 4'd3, "oversize");
        err_case(0, 32'h2, 4'd2, "misaligned");
        err_case(1, 32'h40, 4'd2, "ws3 out of range");
        issue(0, 1'b1, NONSEQ, 32'h0, 4'd2, 1'b0, 32'h0);
        check_rd(0, "after err word0", 32'h0);
        issue(0, 1'b1, NONSEQ, 32'h38, 4'd2, 1'b0, 32'h0);
        check_rd(0, "after err 0x38", 32'h0000_0138);

        // back-to-back with IDLE/BUSY interleaved
        issue(0, 1'b1, NONSEQ, 32'h8, 4'd2, 1'b1, 32'h0000_005A);
        issue(0, 1'b1, NONSEQ, 32'h8, 4'd2, 1'b0, 32'h0);
        check_rd(0, "b2b read", 32'h0000_005A);
        issue(0, 1'b1, IDLE, 32'h8, 4'd2, 1'b1, 32'hFFFF_FFFF);
        issue(0, 1'b1, BUSY, 32'h8, 4'd2, 1'b1, 32'hEEEE_EEEE);
        issue(0, 1'b1, NONSEQ, 32'h8, 4'd2, 1'b0, 32'h0);
        check_rd(0, "idle/busy no effect", 32'h0000_005A);

        // wait states
        issue(1, 1'b1, NONSEQ, 32'h4, 4'd2, 1'b1, 32'hCAFE_F00D);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK); #1;
            if (hready[1]) break;
            n++;
        end
        check_lit("ws3 low cycles", 32'(n), 32'd3);
        drive(1, 1'b1, NONSEQ, 32'h4, 4'd2, 1'b0, 32'h0);
        check_rd(1, "ws3 readback", 32'hCAFE_F00D);

        // reset during WAIT of a write
        issue(1, 1'b1, NONSEQ, 32'h0, 4'd2, 1'b1, 32'h1234_5678);
        issue(1, 1'b1, NONSEQ, 32'h0, 4'd2, 1'b0, 32'h0);
        check_rd(1, "pre-reset word0", 32'h1234_5678);
        issue(1, 1'b1, NONSEQ, 32'h0, 4'd2, 1'b1, 32'hDEAD_BEEF);
        @(negedge HCLK); #3;
        rst_n[1] = 1'b0;
        #1;
        check_lit("mid reset hready", {31'h0, hready[1]}, 32'h1);
        check_lit("mid reset hresp", {31'h0, hresp[1]}, 32'h0);
        check_lit("mid reset hrdata", hrdata[1], 32'h0);
        exp_q[1].delete();
        for (int k = 0; k < 16; k++) mmem[1][k] = 32'h0;
        cur_wd[1] = 32'h0;
        drive(1, 1'b0, IDLE, 32'h0, 4'd0, 1'b0, 32'h0);
        @(negedge HCLK); @(negedge HCLK); #3;
        rst_n[1] = 1'b1;
        issue(1, 1'b1, NONSEQ, 32'h0, 4'd2, 1'b0, 32'h0);
        check_rd(1, "post-reset word0", 32'h0);

        random_run(0, 250);
        random_run(1, 150);
        for (int i = 0; i < 6; i++) begin
            idle(0);
            idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
